// File: rtl/mips_pkg.sv
// Shared fetch-side definitions: NOP encoding, reset vector, PC stepping,
// fetch FSM states and the instruction/next-PC packet held by the skid buffer.
package mips_pkg;

  localparam logic [31:0] NOP_ENC   = 32'h0000_0000;
  localparam logic [31:0] RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] PC_INC    = 32'd4;
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD,
    S_DRAIN
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] npc;
  } fetch_pkt_t;

  // Force an address onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & WORD_MASK;
  endfunction

endpackage

// File: rtl/if_skid_buf.sv
// Single-entry holding register for one fetched (instruction, PC+4) pair.
// Clear wins over load.
module if_skid_buf
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       clear,
  input  fetch_pkt_t din,
  output fetch_pkt_t dout,
  output logic       full
);

  fetch_pkt_t data_q, data_d;
  logic       full_q, full_d;

  // Next-state: clear empties, load captures the incoming packet.
  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (clear) begin
      full_d = 1'b0;
    end else if (load) begin
      data_d = din;
      full_d = 1'b1;
    end
  end

  // Storage registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign dout = data_q;
  assign full = full_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one outstanding request at a
// time to instruction memory and presents registered (ir, pc+4, valid) to
// IF/ID. A returned instruction that cannot be accepted goes to a skid entry.
// Optional build macro IF_PERF_CNT_EN adds fetch / memory-wait counters.
module if_fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_VEC,
  parameter logic [31:0] NOP_INSTR = NOP_ENC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_ir,
  output logic [31:0] if_npc,
  output logic        if_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_wait_cnt
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  tgt_q, tgt_d;
  logic [31:0]  ir_q, ir_d;
  logic [31:0]  npc_q, npc_d;
  logic         valid_q, valid_d;
  logic         req_q, req_d;

  logic         out_free, load_out, skid_ld, skid_clr, skid_full;
  logic [31:0]  pc_inc, tgt_al;
  fetch_pkt_t   fetched, out_pkt, skid_dout;

  assign out_free = !valid_q || !stall;
  assign pc_inc   = pc_q + PC_INC;
  assign tgt_al   = word_align(redirect_target);
  assign fetched  = '{ir: imem_rdata, npc: pc_inc};

  if_skid_buf u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_ld),
    .clear (skid_clr),
    .din   (fetched),
    .dout  (skid_dout),
    .full  (skid_full)
  );

  // Fetch FSM next-state, PC update and output-register load selection.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    tgt_d    = tgt_q;
    ir_d     = ir_q;
    npc_d    = npc_q;
    valid_d  = valid_q;
    out_pkt  = fetched;
    load_out = 1'b0;
    skid_ld  = 1'b0;
    skid_clr = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        if (redirect) pc_d = tgt_al;
      end
      S_FETCH: begin
        if (redirect) begin
          // Returned data is stale; without ready we must wait it out.
          if (imem_ready) begin
            pc_d = tgt_al;
          end else begin
            tgt_d   = tgt_al;
            state_d = S_DRAIN;
          end
        end else if (imem_ready) begin
          pc_d = pc_inc;
          if (out_free) begin
            load_out = 1'b1;
          end else begin
            skid_ld = 1'b1;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (redirect) begin
          skid_clr = 1'b1;
          pc_d     = tgt_al;
          state_d  = S_FETCH;
        end else if (out_free && skid_full) begin
          out_pkt  = skid_dout;
          load_out = 1'b1;
          skid_clr = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_DRAIN: begin
        // Address stays on the abandoned PC until memory answers.
        if (redirect) tgt_d = tgt_al;
        if (imem_ready) begin
          pc_d    = redirect ? tgt_al : tgt_q;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Output register: redirect flush > new load > drain when accepted.
    if (redirect) begin
      valid_d = 1'b0;
      ir_d    = NOP_INSTR;
    end else if (load_out) begin
      valid_d = 1'b1;
      ir_d    = out_pkt.ir;
      npc_d   = out_pkt.npc;
    end else if (!stall) begin
      valid_d = 1'b0;
      ir_d    = NOP_INSTR;
    end

    req_d = (state_d == S_FETCH) || (state_d == S_DRAIN);
  end

  // State, PC and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      tgt_q   <= RESET_PC;
      ir_q    <= NOP_INSTR;
      npc_q   <= 32'd0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      ir_q    <= ir_d;
      npc_q   <= npc_d;
      valid_q <= valid_d;
      req_q   <= req_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign if_ir     = ir_q;
  assign if_npc    = npc_q;
  assign if_valid  = valid_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] wait_cnt_q, wait_cnt_d;

  // Count output loads and request cycles memory left unanswered.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q + {31'd0, load_out};
    wait_cnt_d  = wait_cnt_q + {31'd0, (req_q && !imem_ready)};
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= 32'd0;
      wait_cnt_q  <= 32'd0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_wait_cnt  = wait_cnt_q;
`endif

endmodule
